// File: rtl/slot_pkg.sv
// slot_pkg: shared types and constants for the multi-reel slot machine.
//   state_t    : top-level FSM states (idle, reels spinning, result shown)
//   digit_t    : one decimal reel value, 0..DIGIT_MAX
//   SEG_*      : 7-segment patterns, active-high, bit order {g,f,e,d,c,b,a}
//   digit_step : next reel value for one tick, counting up or down with wrap
package slot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SPIN   = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  typedef logic [3:0] digit_t;

  localparam digit_t DIGIT_MAX = 4'd9;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Up: 0..9 -> 0. Down: 9..0 -> 9. Out-of-range values recover to a legal digit.
  function automatic digit_t digit_step(input digit_t d, input logic down);
    digit_t nxt;
    if (down) nxt = (d == 4'd0 || d > DIGIT_MAX) ? DIGIT_MAX : d - 4'd1;
    else      nxt = (d >= DIGIT_MAX) ? 4'd0 : d + 4'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/decimal_decoder.sv
// decimal_decoder: digit to 7-segment pattern (active-high, {g,f,e,d,c,b,a}).
//   i_digit : value 0..9 (10..15 shows blank)
//   o_seg   : segment pattern
module decimal_decoder
  import slot_pkg::*;
(
  input  digit_t     i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_digit)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/enable_gen.sv
// enable_gen: free-running divider producing a 1-clk enable every 2**WIDTH clocks.
//   clk     : clock
//   i_rst_n : asynchronous active-low reset (counter cleared)
//   o_en    : high for one clock when the counter is all ones
module enable_gen #(
  parameter int WIDTH = 26
) (
  input  logic clk,
  input  logic i_rst_n,
  output logic o_en
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt <= '0;
    else          cnt <= cnt + WIDTH'(1);
  end

  assign o_en = &cnt;

endmodule

// File: rtl/posedge_detector.sv
// posedge_detector: synchronises a level, samples it on each enable and emits a
// 1-clk pulse when the new sample is 1 and the previous sample was 0.
//   clk     : clock
//   i_rst_n : asynchronous active-low reset (sync chain and last sample cleared)
//   i_en    : sample enable (button tick)
//   i_sig   : asynchronous level input, active-high
//   o_pulse : one-clock pulse on a sampled 0->1 transition
module posedge_detector (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_sig,
  output logic o_pulse
);

  logic sync0;
  logic sync1;
  logic prev;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync0 <= i_sig;
      sync1 <= sync0;
      if (i_en) prev <= sync1;
    end
  end

  // The current sample is sync1 itself during the enable cycle, so the pulse
  // lands in the same clock as the sample rather than one clock later.
  assign o_pulse = i_en & sync1 & ~prev;

endmodule

// File: rtl/slot_reel.sv
// slot_reel: one decimal reel, advances on each tick while running.
//   clk     : clock
//   i_rst_n : asynchronous active-low reset (digit -> 0)
//   i_tick  : reel tick pulse
//   i_run   : reel allowed to move this clock
//   i_dir   : 0 = count up 0..9, 1 = count down 9..0
//   o_digit : current reel value
module slot_reel
  import slot_pkg::*;
(
  input  logic   clk,
  input  logic   i_rst_n,
  input  logic   i_tick,
  input  logic   i_run,
  input  logic   i_dir,
  output digit_t o_digit
);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)              o_digit <= '0;
    else if (i_tick && i_run)  o_digit <= digit_step(o_digit, i_dir);
  end

endmodule

// File: rtl/slot_multi.sv
// slot_multi: NUM_REELS-digit slot machine driven by one push button.
// First press starts every reel; each later press stops the leftmost spinning
// reel (reel 0 first). After the last stop o_win reports whether all reels
// show the same digit. A press in RESULT spins all reels again.
//   clk     : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   i_btn_n : raw push button, active-low
//   o_hex   : 7-seg pattern per reel, bits [7i+6:7i] = reel i
//   o_spin  : bit i high while reel i spins
//   o_win   : all reels equal, valid from the first RESULT cycle
//   o_busy  : high in SPIN
// Build option: define SLOT_AUTOSTOP_EN to stop reel k automatically after
// AUTOSTOP_TICKS reel ticks without a stop.
// Button handshake: a press is a single-clock pulse with no back-pressure; it
// is consumed in the clock it appears and ignored in states that do not use it.
module slot_multi
  import slot_pkg::*;
#(
  parameter int NUM_REELS      = 3,
  parameter int EN_CYCLE       = 26,
  parameter int EN_BTN_CYCLE   = 21,
  parameter int AUTOSTOP_TICKS = 8
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  input  logic                   i_btn_n,
  output logic [7*NUM_REELS-1:0] o_hex,
  output logic [NUM_REELS-1:0]   o_spin,
  output logic                   o_win,
  output logic                   o_busy
);

  localparam int KW = (NUM_REELS > 1) ? $clog2(NUM_REELS) : 1;

  if (NUM_REELS < 2 || NUM_REELS > 8) begin : g_bad_reels
    $error("slot_multi: NUM_REELS must be 2..8");
  end
  if (AUTOSTOP_TICKS < 1 || AUTOSTOP_TICKS > 255) begin : g_bad_autostop
    $error("slot_multi: AUTOSTOP_TICKS must be 1..255");
  end

  state_t               state;
  logic [KW-1:0]        k;
  logic                 reel_tick;
  logic                 btn_tick;
  logic                 press;
  logic                 auto_stop;
  logic                 stop_req;
  logic [NUM_REELS-1:0] stop_onehot;
  logic [NUM_REELS-1:0] reel_run;
  logic                 all_eq;
  digit_t               digits [NUM_REELS];

  enable_gen #(.WIDTH(EN_CYCLE)) u_reel_div (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .o_en    (reel_tick)
  );

  enable_gen #(.WIDTH(EN_BTN_CYCLE)) u_btn_div (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .o_en    (btn_tick)
  );

  posedge_detector u_btn_edge (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_en    (btn_tick),
    .i_sig   (~i_btn_n),
    .o_pulse (press)
  );

`ifdef SLOT_AUTOSTOP_EN
  logic [7:0] auto_cnt;

  assign auto_stop = (state == ST_SPIN) && reel_tick &&
                     (auto_cnt == 8'(AUTOSTOP_TICKS - 1));

  // Counts ticks since entering SPIN or since the last stop (press or auto).
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)                          auto_cnt <= '0;
    else if (state != ST_SPIN || stop_req) auto_cnt <= '0;
    else if (reel_tick)                    auto_cnt <= auto_cnt + 8'd1;
  end
`else
  assign auto_stop = 1'b0;
`endif

  // A press and an auto-stop in the same clock collapse into one stop.
  assign stop_req = (state == ST_SPIN) && (press || auto_stop);

  always_comb begin
    stop_onehot = '0;
    for (int i = 0; i < NUM_REELS; i++) begin
      if (stop_req && k == KW'(i)) stop_onehot[i] = 1'b1;
    end
  end

  // Removing the stopping reel from the run mask makes a stop win over a
  // coincident tick: the reel keeps its pre-cycle value.
  assign reel_run = o_spin & ~stop_onehot;

  always_comb begin
    all_eq = 1'b1;
    for (int i = 1; i < NUM_REELS; i++) begin
      if (digits[i] != digits[0]) all_eq = 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_REELS; g++) begin : g_reel
    localparam logic DIR_DOWN = (g % 2) == 1;

    slot_reel u_reel (
      .clk     (clk),
      .i_rst_n (i_rst_n),
      .i_tick  (reel_tick),
      .i_run   (reel_run[g]),
      .i_dir   (DIR_DOWN),
      .o_digit (digits[g])
    );

    decimal_decoder u_dec (
      .i_digit (digits[g]),
      .o_seg   (o_hex[7*g +: 7])
    );
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= ST_IDLE;
      k      <= '0;
      o_spin <= '0;
      o_win  <= 1'b0;
      o_busy <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_RESULT: begin
          if (press) begin
            state  <= ST_SPIN;
            k      <= '0;
            o_spin <= '1;
            o_win  <= 1'b0;
            o_busy <= 1'b1;
          end
        end
        ST_SPIN: begin
          if (stop_req) begin
            o_spin <= o_spin & ~stop_onehot;
            if (k == KW'(NUM_REELS - 1)) begin
              // Digits are all frozen this clock, so the compare is final.
              state  <= ST_RESULT;
              o_win  <= all_eq;
              o_busy <= 1'b0;
            end else begin
              k <= k + KW'(1);
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          k      <= '0;
          o_spin <= '0;
          o_win  <= 1'b0;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slot_multi.sv
// tb_slot_multi: directed bench for slot_multi with NUM_REELS=3, EN_CYCLE=2,
// EN_BTN_CYCLE=1, AUTOSTOP_TICKS=2. Inputs change and outputs are sampled on
// the falling edge; cyc counts rising edges since reset release.
module tb_slot_multi;

  localparam int NR = 3;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            btn_n = 1'b1;
  logic [7*NR-1:0] hex;
  logic [NR-1:0]   spin;
  logic            win;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int cyc;
  int a;

  logic [6:0] seg_tab [10];

  typedef struct {
    int         d0;
    int         d1;
    int         d2;
    logic [2:0] spin;
    logic       busy;
  } vec_t;

  vec_t wrap_tab [10];

  slot_multi #(
    .NUM_REELS      (NR),
    .EN_CYCLE       (2),
    .EN_BTN_CYCLE   (1),
    .AUTOSTOP_TICKS (2)
  ) dut (
    .clk     (clk),
    .i_rst_n (rst_n),
    .i_btn_n (btn_n),
    .o_hex   (hex),
    .o_spin  (spin),
    .o_win   (win),
    .o_busy  (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // ---------------- helpers ----------------
  function automatic logic [6:0] reel_seg(input int i);
    return hex[7*i +: 7];
  endfunction

  function automatic logic [20:0] hex_of(input int d0, input int d1, input int d2);
    return {seg_tab[d2], seg_tab[d1], seg_tab[d0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int target);
    int n = 0;
    while (cyc < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Button held from falling edge p; the stop/start lands on edge a.
  task automatic press(output int act_at);
    int p = cyc;
    btn_n = 1'b0;
    act_at = (p % 2 == 0) ? p + 4 : p + 3;
    wait_cyc(act_at);
    btn_n = 1'b1;
  endtask

  // tie=1: press so the stop coincides with a reel tick while reel i shows target.
  // tie=0: press one cycle before the tick that brings reel i to target.
  task automatic stop_at(input int i, input int target, input bit tie, output int act_at);
    int  want_mod;
    int  want_d;
    bit  found = 1'b0;
    repeat (6) @(negedge clk);
    want_mod = tie ? 0 : 3;
    if (tie)             want_d = target;
    else if (i % 2 == 0) want_d = (target + 9) % 10;
    else                 want_d = (target + 1) % 10;
    for (int n = 0; n < 200; n++) begin
      if (cyc % 4 == want_mod && reel_seg(i) == seg_tab[want_d]) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    act_at = cyc;
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL stop_wait reel%0d: digit %0d never reached, required within 200 cycles", i, want_d);
    end else begin
      press(act_at);
      check($sformatf("stop_digit reel%0d", i), reel_seg(i), seg_tab[target]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    // reel values after k+1 ticks from 0,0,0: reel0 up, reel1 down, reel2 up
    wrap_tab = '{
      '{1, 9, 1, 3'b111, 1'b1}, '{2, 8, 2, 3'b111, 1'b1},
      '{3, 7, 3, 3'b111, 1'b1}, '{4, 6, 4, 3'b111, 1'b1},
      '{5, 5, 5, 3'b111, 1'b1}, '{6, 4, 6, 3'b111, 1'b1},
      '{7, 3, 7, 3'b111, 1'b1}, '{8, 2, 8, 3'b111, 1'b1},
      '{9, 1, 9, 3'b111, 1'b1}, '{0, 0, 0, 3'b111, 1'b1}
    };

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_hex",  32'(hex),  32'(hex_of(0, 0, 0)));
    check("reset_spin", 32'(spin), 32'd0);
    check("reset_win",  32'(win),  32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_hex",  32'(hex),  32'(hex_of(0, 0, 0)));

`ifndef SLOT_AUTOSTOP_EN
    // Spin wrap over 10 ticks
    while (cyc % 4 != 2) @(negedge clk);
    press(a);
    check("start_busy", 32'(busy), 32'd1);
    check("start_spin", 32'(spin), 32'b111);
    check("start_win",  32'(win),  32'd0);
    check("start_hex",  32'(hex),  32'(hex_of(0, 0, 0)));
    for (int k = 0; k < 10; k++) begin
      wait_cyc(a + 2 + 4 * k);
      check($sformatf("wrap_hex t%0d", k + 1), 32'(hex),
            32'(hex_of(wrap_tab[k].d0, wrap_tab[k].d1, wrap_tab[k].d2)));
      check($sformatf("wrap_spin t%0d", k + 1), 32'(spin), 32'(wrap_tab[k].spin));
      check($sformatf("wrap_busy t%0d", k + 1), 32'(busy), 32'(wrap_tab[k].busy));
    end

    // Stop order and win 7,7,7
    stop_at(0, 7, 1'b0, a);
    check("order1_spin", 32'(spin), 32'b110);
    check("order1_busy", 32'(busy), 32'd1);
    stop_at(1, 7, 1'b1, a);
    check("order2_spin", 32'(spin), 32'b100);
    stop_at(2, 7, 1'b0, a);
    check("order3_spin", 32'(spin), 32'b000);
    check("order3_busy", 32'(busy), 32'd0);
    check("win777",      32'(win),  32'd1);
    check("hex777",      32'(hex),  32'(hex_of(7, 7, 7)));
    repeat (8) @(negedge clk);
    check("win777_held", 32'(win),  32'd1);
    check("hex777_held", 32'(hex),  32'(hex_of(7, 7, 7)));

    // Restart from RESULT, then lose with 3,7,7
    while (cyc % 4 != 2) @(negedge clk);
    press(a);
    check("restart_win",  32'(win),  32'd0);
    check("restart_spin", 32'(spin), 32'b111);
    check("restart_busy", 32'(busy), 32'd1);
    stop_at(0, 3, 1'b0, a);
    stop_at(1, 7, 1'b0, a);
    stop_at(2, 7, 1'b1, a);
    check("lose_spin", 32'(spin), 32'b000);
    check("lose_win",  32'(win),  32'd0);
    check("lose_busy", 32'(busy), 32'd0);
    check("lose_hex",  32'(hex),  32'(hex_of(3, 7, 7)));

    // Stop coincident with a tick: reel0 must stay at 4
    while (cyc % 4 != 2) @(negedge clk);
    press(a);
    stop_at(0, 4, 1'b1, a);
    wait_cyc(a + 12);
    check("tie_reel0_held", 32'(reel_seg(0)), 32'(seg_tab[4]));
    check("tie_spin",       32'(spin),        32'b110);

    // Reset mid-spin once reel1 shows 4
    begin
      bit seen = 1'b0;
      for (int n = 0; n < 200; n++) begin
        if (reel_seg(1) == seg_tab[4]) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      if (!seen) begin
        checks++;
        errors++;
        $display("FAIL midreset_wait: reel1 never showed 4, required within 200 cycles");
      end
    end
    rst_n = 1'b0;
    #1;
    check("midreset_hex",  32'(hex),  32'(hex_of(0, 0, 0)));
    check("midreset_spin", 32'(spin), 32'd0);
    check("midreset_win",  32'(win),  32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("postreset_busy", 32'(busy), 32'd0);
    check("postreset_spin", 32'(spin), 32'd0);
    check("postreset_hex",  32'(hex),  32'(hex_of(0, 0, 0)));
`else
    // Auto-stop after 2 ticks per reel, single press
    while (cyc % 4 != 2) @(negedge clk);
    press(a);
    check("auto_start_spin", 32'(spin), 32'b111);
    check("auto_start_busy", 32'(busy), 32'd1);
    wait_cyc(a + 5);
    check("auto_pre_spin", 32'(spin), 32'b111);
    wait_cyc(a + 6);
    check("auto1_spin", 32'(spin), 32'b110);
    check("auto1_reel0", 32'(reel_seg(0)), 32'(seg_tab[1]));
    wait_cyc(a + 14);
    check("auto2_spin", 32'(spin), 32'b100);
    check("auto2_reel1", 32'(reel_seg(1)), 32'(seg_tab[7]));
    wait_cyc(a + 22);
    check("auto3_spin", 32'(spin), 32'b000);
    check("auto3_busy", 32'(busy), 32'd0);
    check("auto3_win",  32'(win),  32'd0);
    check("auto3_hex",  32'(hex),  32'(hex_of(1, 7, 5)));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
